// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO window default,
// register offsets and STATUS bit positions.
package data_mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DFLT = 32'h1000_0000;

  localparam logic [3:0] COUNT_OFF = 4'h0;
  localparam logic [3:0] CMP_OFF   = 4'h4;
  localparam logic [3:0] STAT_OFF  = 4'h8;
  localparam logic [3:0] GPIO_OFF  = 4'hC;

  localparam int unsigned MATCH_BIT = 0;
  localparam int unsigned IEN_BIT   = 1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory port: single-cycle load/store bus with combinational read data.
interface data_mem_responder_if;

  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce_i,
    output we_i,
    output addr_i,
    output sel_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  ce_i,
    input  we_i,
    input  addr_i,
    input  sel_i,
    input  data_i,
    output data_o
  );

endinterface

// File: rtl/data_mem_responder_mmio_timer.sv
// MMIO register block: free-running COUNT with COMPARE match, STATUS (MATCH/IEN),
// GPIO output register and the level timer interrupt.
module data_mem_responder_mmio_timer
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [3:0]        off_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o
);

  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              ien_q, ien_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              irq_q, irq_d;

  always_comb begin
    count_d = count_q + 32'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    ien_d   = ien_q;
    gpio_d  = gpio_q;

    if (wr_en_i) begin
      case (off_i)
        COUNT_OFF: count_d = wdata_i;
        CMP_OFF:   cmp_d   = wdata_i;
        STAT_OFF: begin
          if (wdata_i[MATCH_BIT]) match_d = 1'b0;
          ien_d = wdata_i[IEN_BIT];
        end
        GPIO_OFF:  gpio_d  = wdata_i[GPIO_W-1:0];
        default: ;
      endcase
    end

    // Applied after the write so a same-cycle W1C loses to a fresh match.
    if (count_q == cmp_q) match_d = 1'b1;

    irq_d = match_d & ien_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      ien_q   <= 1'b0;
      gpio_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ien_q   <= ien_d;
      gpio_q  <= gpio_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      COUNT_OFF: rdata_o = count_q;
      CMP_OFF:   rdata_o = cmp_q;
      STAT_OFF: begin
        rdata_o[MATCH_BIT] = match_q;
        rdata_o[IEN_BIT]   = ien_q;
      end
      GPIO_OFF:  rdata_o[GPIO_W-1:0] = gpio_q;
      default: ;
    endcase
  end

  assign gpio_o = gpio_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: address decode, byte-writable RAM with asynchronous read,
// MMIO timer/GPIO block and the registered bad-access pulse.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DFLT,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus,
  output logic [GPIO_W-1:0]   gpio_o,
  output logic                irq_o,
  output logic                err_o
);

  localparam int unsigned IdxW     = $clog2(RAM_WORDS);
  localparam logic [32:0] RamBytes = 33'(RAM_WORDS) << 2;

  logic            is_ram;
  logic            is_mmio;
  logic [31:0]     mmio_delta;
  logic [3:0]      mmio_off;
  logic [IdxW-1:0] ram_idx;
  logic            ram_we;
  logic            mmio_we;
  logic            sel_full;
  logic            err_d;
  logic [31:0]     mmio_rdata;
  logic [31:0]     ram [RAM_WORDS];

  // Offset is taken relative to the base so the window need not be 16-byte aligned.
  assign mmio_delta = bus.addr_i - MMIO_BASE;
  assign is_ram     = {1'b0, bus.addr_i} < RamBytes;
  assign is_mmio    = (bus.addr_i >= MMIO_BASE) && (mmio_delta[31:4] == 28'd0);
  assign mmio_off   = mmio_delta[3:0] & 4'hC;
  assign ram_idx    = bus.addr_i[IdxW+1:2];
  assign sel_full   = (bus.sel_i == 4'hF);

  assign ram_we  = rst && bus.ce_i && bus.we_i && is_ram;
  assign mmio_we = bus.ce_i && bus.we_i && is_mmio && sel_full;
  assign err_d   = bus.ce_i && ((!is_ram && !is_mmio) || (is_mmio && bus.we_i && !sel_full));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sel_i[i]) ram[ram_idx][8*i +: 8] <= bus.data_i[8*i +: 8];
      end
    end
  end

  data_mem_responder_mmio_timer #(
    .GPIO_W (GPIO_W)
  ) u_mmio_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (mmio_we),
    .off_i   (mmio_off),
    .wdata_i (bus.data_i),
    .rdata_o (mmio_rdata),
    .gpio_o  (gpio_o),
    .irq_o   (irq_o)
  );

  always_comb begin
    bus.data_o = '0;
    if (rst && bus.ce_i && !bus.we_i) begin
      if (is_ram) begin
        bus.data_o = ram[ram_idx];
      end else if (is_mmio) begin
        bus.data_o = mmio_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder against a behavioural model.
module tb_data_mem_responder;

  localparam int unsigned RAM_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
  localparam int unsigned GPIO_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [GPIO_W-1:0] gpio_o;
  logic              irq_o;
  logic              err_o;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .MMIO_BASE (MMIO_BASE),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .gpio_o (gpio_o),
    .irq_o  (irq_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       data;
    logic              err;
    logic [GPIO_W-1:0] gpio;
    logic              irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: state as seen after the most recent clock edge.
  logic [31:0]       m_mem [int];
  logic [31:0]       m_count, m_cmp;
  logic              m_match, m_ien, m_irq, m_err;
  logic [GPIO_W-1:0] m_gpio;
  logic [31:0]       unmapped [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_cmp = 0; m_match = 0; m_ien = 0; m_irq = 0; m_err = 0; m_gpio = 0;
  endtask

  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a < RAM_WORDS * 4) return 0;
    if (a >= MMIO_BASE && a < MMIO_BASE + 32'd16) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] mmio_value(input logic [31:0] off);
    case (off)
      0:       return m_count;
      4:       return m_cmp;
      8:       return {30'd0, m_ien, m_match};
      default: return 32'(m_gpio);
    endcase
  endfunction

  task automatic model_step(input logic ce, input logic we, input logic [31:0] a,
                            input logic [3:0] sel, input logic [31:0] wd,
                            output logic [31:0] rd);
    int          r;
    int          key;
    logic [31:0] off;
    logic [31:0] cnt_n;
    logic [31:0] word;
    logic        hit;
    logic        match_n;
    logic        ien_n;
    r       = region(a);
    key     = int'(a >> 2);
    off     = (a - MMIO_BASE) & 32'hC;
    hit     = (m_count == m_cmp);
    cnt_n   = m_count + 32'd1;
    match_n = m_match;
    ien_n   = m_ien;
    rd      = 0;
    if (ce && !we) begin
      if (r == 0) rd = m_mem[key];
      else if (r == 1) rd = mmio_value(off);
    end
    m_err = ce && (r == 2 || (r == 1 && we && sel != 4'hF));
    if (ce && we && r == 0) begin
      word = m_mem[key];
      for (int i = 0; i < 4; i++) if (sel[i]) word[8*i +: 8] = wd[8*i +: 8];
      m_mem[key] = word;
    end
    if (ce && we && r == 1 && sel == 4'hF) begin
      case (off)
        0: cnt_n = wd;
        4: m_cmp = wd;
        8: begin
          if (wd[0]) match_n = 0;
          ien_n = wd[1];
        end
        default: m_gpio = wd[GPIO_W-1:0];
      endcase
    end
    if (hit) match_n = 1;
    m_count = cnt_n;
    m_match = match_n;
    m_ien   = ien_n;
    m_irq   = match_n & ien_n;
  endtask

  // Drive one access for the current cycle and queue what the DUT must show.
  task automatic apply(input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] wd);
    exp_t e;
    bus.ce_i = ce; bus.we_i = we; bus.addr_i = a; bus.sel_i = sel; bus.data_i = wd;
    e.err  = m_err;
    e.gpio = m_gpio;
    e.irq  = m_irq;
    model_step(ce, we, a, sel, wd, e.data);
    exp_q.push_back(e);
  endtask

  task automatic do_cycle(input logic ce, input logic we, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] wd);
    @(posedge clk);
    #1;
    apply(ce, we, a, sel, wd);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(1'b1, 1'b0, a, 4'hF, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
    do_cycle(1'b1, 1'b1, a, sel, wd);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_o", bus.data_o, e.data);
        check("err_o", 32'(err_o), 32'(e.err));
        check("gpio_o", 32'(gpio_o), 32'(e.gpio));
        check("irq_o", 32'(irq_o), 32'(e.irq));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int guard;
    unmapped[0] = 32'h2000_0000;
    unmapped[1] = RAM_WORDS * 4;
    unmapped[2] = MMIO_BASE - 32'd4;
    unmapped[3] = MMIO_BASE + 32'd16;
    unmapped[4] = 32'hFFFF_FFFC;
    model_reset();
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = MMIO_BASE; bus.sel_i = 4'hF; bus.data_i = 0;
    #2;
    check("reset_data_o", bus.data_o, 32'd0);
    check("reset_gpio", 32'(gpio_o), 32'd0);
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(1'b1, 1'b0, MMIO_BASE, 4'hF, 32'd0);
    // Known contents for every RAM word the random phase may touch.
    for (int w = 0; w < 16; w++) begin
      m_mem[w] = 32'd0;
      wr(32'(w) << 2, 4'hF, $urandom);
    end
    m_mem[RAM_WORDS-1] = 32'd0;
    wr(32'(RAM_WORDS - 1) << 2, 4'hF, $urandom);

    // Timer compare and interrupt, then W1C.
    wr(MMIO_BASE + 4, 4'hF, 32'd20);
    wr(MMIO_BASE + 8, 4'hF, 32'h2);
    guard = 0;
    while (!m_irq && guard < 40) begin
      rd(MMIO_BASE + 8);
      guard++;
    end
    rd(MMIO_BASE + 8);
    #2;
    check("irq_after_match", 32'(irq_o), 32'd1);
    wr(MMIO_BASE + 8, 4'hF, 32'h1);
    rd(MMIO_BASE + 8);
    #2;
    check("irq_after_w1c", 32'(irq_o), 32'd0);

    // Clear/set collision.
    wr(MMIO_BASE + 8, 4'hF, 32'h2);
    wr(MMIO_BASE + 4, 4'hF, 32'd105);
    wr(MMIO_BASE + 0, 4'hF, 32'd100);
    for (int i = 0; i < 8; i++) rd(MMIO_BASE + 0);
    wr(MMIO_BASE + 0, 4'hF, 32'd100);
    guard = 0;
    while (m_count != 32'd105 && guard < 20) begin
      rd(MMIO_BASE + 0);
      guard++;
    end
    wr(MMIO_BASE + 8, 4'hF, 32'h3);
    rd(MMIO_BASE + 8);
    #2;
    check("collision_status", bus.data_o, 32'h3);
    check("collision_irq", 32'(irq_o), 32'd1);

    // COUNT load and wrap.
    wr(MMIO_BASE + 0, 4'hF, 32'hFFFF_FFFE);
    rd(MMIO_BASE + 0);
    rd(MMIO_BASE + 0);
    #2;
    check("count_wrap_ff", bus.data_o, 32'hFFFF_FFFF);
    rd(MMIO_BASE + 0);
    #2;
    check("count_wrap_0", bus.data_o, 32'd0);

    // Byte-lane store.
    wr(32'h10, 4'hF, 32'hAABB_CCDD);
    wr(32'h10, 4'b0010, 32'h0000_1100);
    rd(32'h10);
    #2;
    check("byte_lane", bus.data_o, 32'hAABB_11DD);
    do_cycle(1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
    #2;
    check("ce_low_read", bus.data_o, 32'd0);

    // Error cases and GPIO.
    rd(32'h2000_0000);
    #2;
    check("unmapped_data", bus.data_o, 32'd0);
    rd(32'h10);
    #2;
    check("unmapped_err", 32'(err_o), 32'd1);
    rd(32'h10);
    #2;
    check("err_not_sticky", 32'(err_o), 32'd0);
    wr(MMIO_BASE + 12, 4'b0011, 32'h5A);
    rd(32'h10);
    #2;
    check("gpio_bad_sel", 32'(gpio_o), 32'd0);
    check("gpio_bad_err", 32'(err_o), 32'd1);
    wr(MMIO_BASE + 12, 4'hF, 32'h1A5);
    rd(MMIO_BASE + 12);
    #2;
    check("gpio_write", 32'(gpio_o), 32'hA5);

    // Asynchronous reset mid-count.
    @(posedge clk);
    #3;
    check("pre_reset_gpio", 32'(gpio_o), 32'hA5);
    check("pre_reset_irq", 32'(irq_o), 32'd1);
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10; bus.sel_i = 4'hF;
    rst = 1'b0;
    #1;
    check("async_gpio", 32'(gpio_o), 32'd0);
    check("async_irq", 32'(irq_o), 32'd0);
    check("async_err", 32'(err_o), 32'd0);
    check("async_data", bus.data_o, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    apply(1'b1, 1'b0, MMIO_BASE, 4'hF, 32'd0);
    rd(MMIO_BASE);
    #2;
    check("count_after_reset", bus.data_o, 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 500; n++) begin
      int          k;
      int          w;
      logic        ce;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] off;
      k   = $urandom_range(0, 9);
      ce  = 1'b1;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      wd  = $urandom;
      if (k < 5) begin
        w = $urandom_range(0, 16);
        if (w == 16) w = RAM_WORDS - 1;
        a = (32'(w) << 2) | 32'($urandom_range(0, 3));
      end else if (k < 8) begin
        a   = MMIO_BASE + 32'($urandom_range(0, 15));
        off = (a - MMIO_BASE) & 32'hC;
        if ($urandom_range(0, 3) != 0) sel = 4'hF;
        if (off == 4) wd = m_count + 32'($urandom_range(1, 6));
        else if (off == 0 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else if (k == 8) begin
        a = unmapped[$urandom_range(0, 4)];
      end else begin
        ce = 1'b0;
        a  = $urandom;
      end
      do_cycle(ce, we, a, sel, wd);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
